seq_restoring_divider: RTL
==========================

Name: seq_restoring_divider

Overview:
- Multi-cycle unsigned restoring divider; the inverse operation of the team's 4x4 Wallace-tree multiplier.
- Takes a 2N-bit dividend and an N-bit divisor. Produces a 2N-bit quotient and an N-bit remainder, one quotient bit per clock.
- Sits beside the multiplier in the mult/div unit. Operands are accepted through a start/busy handshake; results are announced with a done pulse.

Parameters:
- N, 4: divisor and remainder width. Dividend and quotient are 2N bits wide.

Ports:
- clk  input  1  the single clock; all state changes on its rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request to begin a division; sampled on a rising edge
- dividend  input  2N  unsigned dividend; sampled when start is accepted
- divisor  input  N  unsigned divisor; sampled when start is accepted
- busy  output  1  high while a division is in progress; start is ignored while busy
- done  output  1  one-cycle pulse; quotient, remainder and dbz are valid from this cycle
- quotient  output  2N  unsigned quotient
- remainder  output  N  unsigned remainder
- dbz  output  1  divide-by-zero flag for the last completed operation

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-low.
  - rst_n low forces, immediately and independent of clk: state=IDLE, busy=0, done=0, quotient=0, remainder=0, dbz=0, internal counter=0, partial remainder=0.
  - Reset mid-operation aborts the division. No done pulse follows, and no partial result is visible.
- States and transitions:
  - IDLE -> RUN: start=1 and divisor!=0 at edge E0.
  - IDLE -> ZERO: start=1 and divisor==0 at E0.
  - RUN -> IDLE: after the 2N-th step.
  - ZERO -> IDLE: after one cycle.
- Accept (edge E0):
  - Latch dividend into the shift register and divisor into the divisor register.
  - Clear the partial remainder (N+1 bits) and load the counter with 2N.
  - Set busy=1 and done=0.
  - A start is accepted only when busy=0. That includes the done cycle, so back-to-back operations are allowed.
- RUN step (edges E1..E2N), one per edge:
  - Shift {partial remainder, dividend register} left by 1.
  - Trial subtract: trial = partial_rem - {1'b0, divisor}, computed N+1 bits wide.
  - trial non-negative (MSB=0): partial_rem = trial, shift in quotient bit 1.
  - trial negative: restore the partial remainder, shift in quotient bit 0.
  - Decrement the counter.
- Completion at E2N:
  - Write quotient and remainder (low N bits of the partial remainder).
  - Set dbz=0, busy=0, done=1.
  - done drops at E2N+1 unless a new completion occurs.
  - Latency: done is high in the cycle after edge E0+2N (8 cycles for N=4).
- Divide by zero:
  - At E0+1: quotient = all ones (2N bits), remainder = dividend[N-1:0], dbz=1, busy=0, done=1.
  - Latency 1 cycle.
- Output holding: quotient, remainder and dbz hold their values until the next completion. They are not cleared on a new accept.
- Handshake edge cases:
  - start held high while busy: ignored; no queueing.
  - start high in the done cycle: accepted as a new E0.
  - Changes on dividend/divisor after E0 have no effect.
- Arithmetic: everything is unsigned. The result always satisfies dividend == quotient*divisor + remainder, with remainder < divisor.
  - Quotient may exceed N bits (e.g. 255/1), hence its 2N width.

Test Plan:
- Exhaustive inverse check: for all a,b in 0..15 with b!=0, dividend=a*b, divisor=b -> quotient=a, remainder=0, dbz=0; done arrives exactly 8 cycles after accept.
- Non-exact: 200/7 -> quotient=28, remainder=4. 255/1 -> quotient=255, remainder=0. 5/15 -> quotient=0, remainder=5.
- Divide by zero: 0xA5/0 -> done one cycle after accept, quotient=0xFF, remainder=0x5, dbz=1. A following 9/3 -> quotient=3, remainder=0, dbz=0.
- Handshake: start pulsed at cycles 3 and 4 of an active 100/9 -> single done, quotient=11, remainder=1. start raised in the done cycle -> second operation accepted, with no idle cycle between them.
- Reset mid-op: 200/7 started, rst_n asserted asynchronously at cycle 4 -> all outputs 0 immediately, no done pulse. After release, 50/5 -> quotient=10, remainder=0.
- Result hold: after 13/4 completes (quotient=3, remainder=1), idle for 20 cycles -> outputs stable and done low throughout.

Source files
------------

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: 2N-bit dividend / N-bit divisor,
// one quotient bit per clock, start/busy handshake with a done pulse.
module seq_restoring_divider #(
   parameter int unsigned N = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2*N-1:0]   dividend,
   input  logic [N-1:0]     divisor,
   output logic             busy,
   output logic             done,
   output logic [2*N-1:0]   quotient,
   output logic [N-1:0]     remainder,
   output logic             dbz
);

   localparam int unsigned W  = 2 * N;
   localparam int unsigned CW = $clog2(W + 1);

   typedef enum logic [1:0] {IDLE, RUN, ZERO} state_t;

   state_t         state, state_n;
   logic           busy_n, done_n, dbz_n;
   logic [W-1:0]   quotient_n;
   logic [N-1:0]   remainder_n;
   logic [CW-1:0]  cnt, cnt_n;
   logic [N:0]     prem, prem_n;
   logic [W-1:0]   dreg, dreg_n;
   logic [N-1:0]   dvs, dvs_n;

   // One restoring step; the extra top bit of the trial is the borrow
   logic [N+1:0]   shifted;
   logic [N+1:0]   trial;
   logic           qbit;
   logic [N:0]     step_rem;
   logic [W-1:0]   step_q;

   assign shifted  = {prem, dreg[W-1]};
   assign trial    = shifted - {2'b00, dvs};
   assign qbit     = ~trial[N+1];
   assign step_rem = qbit ? trial[N:0] : shifted[N:0];
   assign step_q   = {dreg[W-2:0], qbit};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         dbz       <= 1'b0;
         cnt       <= '0;
         prem      <= '0;
         dreg      <= '0;
         dvs       <= '0;
      end else begin
         state     <= state_n;
         busy      <= busy_n;
         done      <= done_n;
         quotient  <= quotient_n;
         remainder <= remainder_n;
         dbz       <= dbz_n;
         cnt       <= cnt_n;
         prem      <= prem_n;
         dreg      <= dreg_n;
         dvs       <= dvs_n;
      end
   end

   always_comb begin
      state_n     = state;
      busy_n      = busy;
      done_n      = 1'b0;
      quotient_n  = quotient;
      remainder_n = remainder;
      dbz_n       = dbz;
      cnt_n       = cnt;
      prem_n      = prem;
      dreg_n      = dreg;
      dvs_n       = dvs;

      case (state)
         IDLE: begin
            if (start && !busy) begin
               dreg_n  = dividend;
               dvs_n   = divisor;
               prem_n  = '0;
               cnt_n   = CW'(W);
               busy_n  = 1'b1;
               state_n = (divisor == '0) ? ZERO : RUN;
            end
         end
         RUN: begin
            prem_n = step_rem;
            dreg_n = step_q;
            cnt_n  = cnt - CW'(1);
            if (cnt == CW'(1)) begin
               quotient_n  = step_q;
               remainder_n = step_rem[N-1:0];
               dbz_n       = 1'b0;
               busy_n      = 1'b0;
               done_n      = 1'b1;
               state_n     = IDLE;
            end
         end
         ZERO: begin
            quotient_n  = '1;
            remainder_n = dreg[N-1:0];
            dbz_n       = 1'b1;
            busy_n      = 1'b0;
            done_n      = 1'b1;
            state_n     = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

endmodule
